// File: rtl/reg_pair_access.sv
// Sequencer that turns execute-stage register ops into timed nibble accesses on the 16x4 register file.
// Optional REGPAIR_B2B_EN: accept the next request in RESP so back-to-back ops save the IDLE cycle.
module reg_pair_access #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [AW-1:0] req_idx,
  input  logic [7:0]    req_wdata,
  output logic          rsp_valid,
  output logic [7:0]    rsp_data,
  output logic          rsp_zero,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [3:0]    rf_din,
  input  logic [3:0]    rf_dout
);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_XCH = 2'b10;
  localparam logic [1:0] OP_INC = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_op;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_wdata;
  logic [3:0]    r_hi;
  logic [7:0]    r_rsp_data;
  logic          r_rsp_zero;

  logic          w_accept;
  logic          w_pair;
  logic [AW-1:0] w_addr_hi;
  logic [AW-1:0] w_addr_lo;
  logic [3:0]    w_inc;
  logic          w_cap;
  logic [7:0]    w_rsp_data_nxt;
  logic          w_rsp_zero_nxt;

  assign w_accept  = req_valid & req_ready;
  assign w_pair    = ~r_op[1];
  assign w_addr_hi = {r_idx[AW-1:1], 1'b0};
  assign w_addr_lo = {r_idx[AW-1:1], 1'b1};
  assign w_inc     = rf_dout + 4'd1;

  assign rsp_data  = r_rsp_data;
  assign rsp_zero  = r_rsp_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // rf_* depend only on state, latched fields and rf_dout; req_* never reach the file
  always_comb begin
    w_state_nxt    = r_state;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rf_we          = 1'b0;
    rf_addr        = '0;
    rf_din         = '0;
    w_cap          = 1'b0;
    w_rsp_data_nxt = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = S_ACC0;
      end
      S_ACC0: begin
        rf_addr = w_pair ? w_addr_hi : r_idx;
        case (r_op)
          OP_RD: w_state_nxt = S_ACC1;
          OP_WR: begin
            rf_we       = 1'b1;
            rf_din      = r_wdata[7:4];
            w_state_nxt = S_ACC1;
          end
          OP_XCH: begin
            // read-before-write: old value is sampled in the same cycle it is overwritten
            rf_we          = 1'b1;
            rf_din         = r_wdata[3:0];
            w_cap          = 1'b1;
            w_rsp_data_nxt = {4'h0, rf_dout};
            w_state_nxt    = S_RESP;
          end
          OP_INC: begin
            rf_we          = 1'b1;
            rf_din         = w_inc;
            w_cap          = 1'b1;
            w_rsp_data_nxt = {4'h0, w_inc};
            w_state_nxt    = S_RESP;
          end
          default: w_state_nxt = S_IDLE;
        endcase
      end
      S_ACC1: begin
        rf_addr        = w_addr_lo;
        w_cap          = 1'b1;
        w_rsp_data_nxt = (r_op == OP_RD) ? {r_hi, rf_dout} : 8'h00;
        if (r_op == OP_WR) begin
          rf_we  = 1'b1;
          rf_din = r_wdata[3:0];
        end
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
`ifdef REGPAIR_B2B_EN
        req_ready   = 1'b1;
        w_state_nxt = req_valid ? S_ACC0 : S_IDLE;
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // a write-pair result is never reported as zero
  assign w_rsp_zero_nxt = (w_rsp_data_nxt == 8'h00) && (r_op != OP_WR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_hi       <= '0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op    <= req_op;
        r_idx   <= req_idx;
        r_wdata <= req_wdata;
      end
      if (r_state == S_ACC0 && r_op == OP_RD) r_hi <= rf_dout;
      if (w_cap) begin
        r_rsp_data <= w_rsp_data_nxt;
        r_rsp_zero <= w_rsp_zero_nxt;
      end
    end
  end

endmodule

// File: tb/tb_reg_pair_access.sv
// Randomized bench for reg_pair_access with an op-level register model; honours REGPAIR_B2B_EN.
module tb_reg_pair_access;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = '0;
  logic [3:0] req_idx = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_zero;
  logic       rf_we;
  logic [3:0] rf_addr;
  logic [3:0] rf_din;
  logic [3:0] rf_dout;

  int n_tests = 0;
  int n_fail  = 0;

  reg_pair_access #(.AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_idx(req_idx), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_din(rf_din), .rf_dout(rf_dout)
  );

  always #5 clk = ~clk;

  // register file: combinational read, clocked write, shares rst_n
  logic [3:0] mem [16];
  assign rf_dout = mem[rf_addr];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 4'h0;
    end else if (rf_we) begin
      mem[rf_addr] <= rf_din;
    end
  end

  // reference model: register contents and expected write list at op granularity
  logic [3:0] mdl [16];
  logic [7:0] exp_w[$];
  logic [7:0] obs_w[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_op(input logic [1:0] op, input logic [3:0] idx, input logic [7:0] wd,
                          output logic [7:0] d, output logic z);
    int hi;
    int nv;
    hi = (idx / 2) * 2;
    case (op)
      2'd0: begin
        d = mdl[hi] * 16 + mdl[hi+1];
        z = (d == 0);
      end
      2'd1: begin
        mdl[hi]   = wd[7:4];
        mdl[hi+1] = wd[3:0];
        exp_w.push_back({4'(hi), wd[7:4]});
        exp_w.push_back({4'(hi + 1), wd[3:0]});
        d = 8'h00;
        z = 1'b0;
      end
      2'd2: begin
        d = {4'h0, mdl[idx]};
        z = (mdl[idx] == 0);
        mdl[idx] = wd[3:0];
        exp_w.push_back({idx, wd[3:0]});
      end
      default: begin
        nv = (mdl[idx] + 1) % 16;
        mdl[idx] = 4'(nv);
        d = 8'(nv);
        z = (nv == 0);
        exp_w.push_back({idx, 4'(nv)});
      end
    endcase
  endtask

  // single op issued from IDLE; checks latency, response, write list and hold behaviour
  task automatic do_op(input logic [1:0] op, input logic [3:0] idx, input logic [7:0] wd, input string tag);
    logic [7:0] ed;
    logic       ez;
    int         cyc;
    bit         seen;
    @(negedge clk);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_idle_we"}, 32'({rf_we, rf_addr, rf_din}), 32'd0);
    exp_w.delete();
    obs_w.delete();
    model_op(op, idx, wd, ed, ez);
    req_valid = 1'b1; req_op = op; req_idx = idx; req_wdata = wd;
    cyc = 0;
    seen = 0;
    while (!seen && cyc < 10) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        req_valid = $urandom_range(0, 1);
        req_op    = 2'($urandom);
        req_idx   = 4'($urandom);
        req_wdata = 8'($urandom);
      end
      if (rf_we) obs_w.push_back({rf_addr, rf_din});
      if (rsp_valid) begin
        seen = 1;
        req_valid = 1'b0;
        chk({tag, "_lat"}, 32'(cyc), (op[1] == 1'b0) ? 32'd3 : 32'd2);
        chk({tag, "_data"}, 32'(rsp_data), 32'(ed));
        chk({tag, "_zero"}, 32'(rsp_zero), 32'(ez));
      end
    end
    req_valid = 1'b0;
    if (!seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_nwr"}, 32'(obs_w.size()), 32'(exp_w.size()));
    for (int i = 0; i < obs_w.size() && i < exp_w.size(); i++)
      chk({tag, "_wr"}, 32'(obs_w[i]), 32'(exp_w[i]));
    @(negedge clk);
    chk({tag, "_pulse1"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_hold"}, 32'({rsp_zero, rsp_data}), 32'({ez, ed}));
  endtask

  task automatic b2b_run(input int n);
    logic [1:0] ops [$];
    logic [8:0] exp_r[$];
    logic [7:0] ed;
    logic       ez;
    logic [8:0] er;
    logic [1:0] prev_op;
    int k, nrsp, cyc, last, gap;
    k = 0; nrsp = 0; cyc = 0; last = -1; prev_op = 2'd0;
    while ((k < n || nrsp < n) && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        if (exp_r.size() == 0) chk("b2b_extra_rsp", 32'd1, 32'd0);
        else begin
          er = exp_r.pop_front();
          chk("b2b_rsp", 32'({rsp_zero, rsp_data}), 32'(er));
        end
        nrsp++;
      end
      if (req_ready) begin
        if (k < n) begin
          if (last >= 0) begin
`ifdef REGPAIR_B2B_EN
            gap = (prev_op[1] == 1'b0) ? 3 : 2;
`else
            gap = (prev_op[1] == 1'b0) ? 4 : 3;
`endif
            chk("b2b_gap", 32'(cyc - last), 32'(gap));
          end
          prev_op   = 2'($urandom);
          req_op    = prev_op;
          req_idx   = 4'($urandom);
          req_wdata = 8'($urandom);
          req_valid = 1'b1;
          model_op(req_op, req_idx, req_wdata, ed, ez);
          exp_r.push_back({ez, ed});
          last = cyc;
          k++;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    exp_w.delete();
    chk("b2b_nrsp", 32'(nrsp), 32'(n));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 4'h0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_outs", 32'({rsp_valid, rsp_data, rsp_zero, rf_we, rf_addr, rf_din}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(2'd0, 4'd4, 8'h00, "rd_zero");
    do_op(2'd1, 4'd6, 8'hA5, "wr_a5");
    do_op(2'd0, 4'd7, 8'h00, "rd_a5");
    do_op(2'd2, 4'd3, 8'h09, "xch_pre");
    do_op(2'd2, 4'd3, 8'h02, "xch");
    chk("xch_r3", 32'(mem[3]), 32'd2);
    do_op(2'd1, 4'd0, 8'h0F, "wr_r1f");
    do_op(2'd3, 4'd1, 8'h00, "inc_wrap");
    do_op(2'd3, 4'd1, 8'h00, "inc_one");

    // reset in the middle of a pair write
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_idx = 4'd2; req_wdata = 8'h3C;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_acc0_we", 32'(rf_we), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", 32'({rsp_valid, rsp_data, rsp_zero, rf_we, rf_addr, rf_din}), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_mem", 32'({mem[2], mem[3]}), 32'd0);
    for (int i = 0; i < 16; i++) mdl[i] = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    do_op(2'd0, 4'd2, 8'h00, "rd_after_rst");

    b2b_run(12);

    for (int t = 0; t < 40; t++)
      do_op(2'($urandom), 4'($urandom), 8'($urandom), "rnd");

    for (int i = 0; i < 16; i++) chk("final_mem", 32'(mem[i]), 32'(mdl[i]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_pair_access.md
Name: reg_pair_access

Overview:
- Sequencer that sits between the CPU execute stage and the 16×4-bit single-port register file.
- Turns one-shot register operations into timed single-nibble accesses on the file's we/addr/din/dout port:
  - 8-bit register-pair read and write (FIM/SRC/FIN/JIN style)
  - nibble exchange (XCH style)
  - nibble increment (INC/ISZ style)
- Execute stage uses a valid/ready request and a one-cycle response pulse.
- Register file read is combinational, so each access nibble takes one cycle.

Parameters:
- AW, 4, register-file address width (2^AW registers; pair index width is AW-1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept a request
- req_op  in  2  00 RD_PAIR, 01 WR_PAIR, 10 XCH, 11 INC
- req_idx  in  AW  register index; pair ops use req_idx[AW-1:1], bit 0 ignored
- req_wdata  in  8  pair write data (WR_PAIR); XCH new nibble in [3:0]; unused for RD_PAIR/INC
- rsp_valid  out  1  one-cycle pulse, result valid
- rsp_data  out  8  result (see Behaviour)
- rsp_zero  out  1  result-equals-zero flag, valid with rsp_valid
- rf_we  out  1  register-file write enable
- rf_addr  out  AW  register-file address
- rf_din  out  4  register-file write data
- rf_dout  in  4  register-file combinational read data

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk.
  - State goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_data=0, rsp_zero=0, rf_we=0, rf_addr=0, rf_din=0.
  - Latched op/idx/wdata and the capture registers clear to 0.
- Pair mapping: pair p → high nibble at address 2p, low nibble at address 2p+1.
- States: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready at a rising edge: latch op, idx, wdata; go to ACC0.
- ACC0 (req_ready=0):
  - rf_addr = 2p for pair ops; rf_addr = idx for XCH/INC.
  - RD_PAIR: capture rf_dout into hi at the edge; go to ACC1.
  - WR_PAIR: rf_we=1, rf_din=wdata[7:4]; go to ACC1.
  - XCH: capture old=rf_dout; rf_we=1, rf_din=wdata[3:0] (read-before-write in the same cycle); go to RESP.
  - INC: rf_we=1, rf_din=(rf_dout+1) mod 16; capture the new value; go to RESP.
- ACC1 (req_ready=0):
  - rf_addr = 2p+1.
  - RD_PAIR: capture lo; go to RESP.
  - WR_PAIR: rf_we=1, rf_din=wdata[3:0]; go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle; go to IDLE.
  - rsp_data and rsp_zero per op:
    - RD_PAIR: rsp_data={hi,lo}; rsp_zero=(data==0).
    - WR_PAIR: rsp_data=0; rsp_zero=0.
    - XCH: rsp_data={4'h0,old}; rsp_zero=(old==0).
    - INC: rsp_data={4'h0,new}; rsp_zero=(new==0), i.e. ISZ semantics, 4'hF wraps to 0 and gives zero=1.
  - rsp_data and rsp_zero hold their last value outside RESP.
- Outside ACC0/ACC1: rf_we=0, rf_addr=0, rf_din=0.
  - All outputs are registered-state decodes.
  - rf_* are combinational from state and latched fields, never from req_* directly.
- Latency, from accept edge E0:
  - Pair ops: rsp_valid high between E2 and E3.
  - XCH/INC: rsp_valid high between E1 and E2.
  - Throughput: 4 cycles per pair op, 3 per single op.
- No response backpressure: the consumer must take rsp_* in the pulse cycle.
- Request inputs are ignored while req_ready=0. Changes to req_* after acceptance have no effect.
- Reset mid-operation:
  - Sequencer returns to IDLE immediately, no further writes.
  - The register file shares rst_n, so a half-written pair is cleared with it.
- Writes never touch any address other than those listed above.

Optional Feature:
- Macro REGPAIR_B2B_EN.
- Defined:
  - req_ready=1 in RESP as well as IDLE.
  - A request accepted in RESP goes straight to ACC0 while the current rsp_valid pulse still completes.
  - Throughput becomes 3 cycles per pair op and 2 per single op.
- Undefined:
  - req_ready=0 in RESP; a request must wait for IDLE.

Test Plan:
- Reset, then RD_PAIR idx=4 with R4=0, R5=0 → rf_we never asserted; rsp_valid 3 cycles after accept; rsp_data=8'h00; rsp_zero=1.
- WR_PAIR idx=6 wdata=8'hA5, then RD_PAIR idx=7 (bit 0 ignored) → writes R6=4'hA then R7=4'h5 on consecutive cycles; read returns rsp_data=8'hA5, rsp_zero=0.
- R3=4'h9; XCH idx=3 wdata=8'h02 → single cycle with rf_we=1, rf_addr=3, rf_din=2; rsp_data=8'h09; R3 reads 4'h2 afterwards.
- R1=4'hF; INC idx=1 → rf_din=0; rsp_data=8'h00, rsp_zero=1. Repeat INC → rsp_data=8'h01, rsp_zero=0.
- WR_PAIR idx=2 wdata=8'h3C with rst_n pulsed low during ACC1 → outputs zero at once; state IDLE; R2 and R3 read 0 after reset; req_ready=1.
- req_valid held high for back-to-back requests, with and without REGPAIR_B2B_EN → accept edges spaced 4 (pair) / 3 (single) cycles without the macro, 3 / 2 with it; no response is dropped.
